mdu_sched: RTL and testbench
============================

// Module: mdu_sched
// PURPOSE
//  Multiply/divide unit sequencer for the E stage. Accepts the E-stage MDU op
//  (MDUOpE plus the forwarded operands). Runs mult/div as multi-cycle operations
//  and owns the HI/LO registers. Raises the D-stage stall request that freezes
//  the D->E pipeline register while an MDU-dependent instruction waits. Ops are
//  suppressed on an exception/interrupt request (req).
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for mult/multu (>=1)
//  DIV_CYCLES   10  busy cycles for div/divu (>=1)
// PORTS
//  clk        in   1   clock, rising edge
//  reset      in   1   synchronous, active-high
//  op_e       in   4   E-stage op: 0 none,1 mult,2 multu,3 div,4 divu,5 mfhi,6 mflo,7 mthi,8 mtlo
//  rs_e       in   32  forwarded rs operand
//  rt_e       in   32  forwarded rt operand
//  req        in   1   exception/interrupt flush this cycle
//  d_is_mdu   in   1   D-stage instr is any MDU op (1..8)
//  busy       out  1   mult/div in flight
//  stall_d    out  1   stall request to D->E register and upstream
//  rdata_e    out  32  mfhi/mflo result, valid same cycle
//  hi, lo     out  32  architectural HI/LO (debug/observe)
// BEHAVIOUR
//  Reset: state IDLE, counter 0, busy=0, hi=lo=0, internal product/quotient regs 0.
//  Reset in mid-op aborts; HI/LO=0 next cycle; reset has priority over all.
//  FSM IDLE/RUN, down-counter cnt:
//   IDLE & op_e in 1..4 & !req: latch result, load cnt = MULT_CYCLES or DIV_CYCLES,
//     go RUN next edge.
//   RUN: cnt decrements each cycle. At cnt==1, HI/LO written at that edge, go IDLE.
//     busy=1 for exactly N cycles after the start edge.
//   So an op started at edge t makes HI/LO visible from edge t+N.
//  start (combinational) = (state==IDLE) & op_e in 1..4 & !req.
//  busy = (state==RUN); busy does not include the start cycle itself.
//  stall_d = d_is_mdu & (busy | start). A stall never blocks a non-MDU D instr.
//  op_e in 1..4 while RUN cannot occur, because stall_d prevents it. If it does
//    occur, it is ignored (assertion in bench).
//  mthi/mtlo (7/8) & !req & IDLE: HI/LO <= rs_e at the next edge.
//  mfhi/mflo: rdata_e = hi/lo combinational; rdata_e = 0 for other ops.
//  req=1: no start, no mthi/mtlo write. An op already in RUN completes normally.
//  Arithmetic:
//   mult  {HI,LO} = signed 64-bit rs*rt.
//   multu {HI,LO} = unsigned 64-bit rs*rt.
//   div/divu: LO = quotient, HI = remainder. Signed division truncates toward
//     zero; the remainder takes the sign of the dividend.
//   div 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
//   Divisor 0: the op still runs for DIV_CYCLES but HI/LO are left unchanged.
//  Result is computed at start and held in a pending register. Only the commit is
//   delayed, so a later change on rs_e/rt_e during RUN has no effect.
// TESTING
//  1 mult rs=0xFFFFFFFE, rt=3 -> busy 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
//    multu with the same operands -> HI=0x2, LO=0xFFFFFFFA.
//  2 div rs=-7 (0xFFFFFFF9), rt=2 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//    divu 7/0 -> HI/LO unchanged and busy for 10 cycles.
//  3 mult, then d_is_mdu=1 (mflo) -> stall_d=1 in the start cycle and the 5 busy
//    cycles; it drops when busy drops. mflo then reads the new LO; non-MDU D never stalls.
//  4 req=1 with op_e=div, or req=1 with mthi -> no busy, HI/LO unchanged.
//    req during RUN -> the op still commits.
//  5 reset on the 3rd busy cycle -> next cycle busy=0, HI=LO=0, stall_d=0.
//  6 mthi 0x1234 then mfhi the next cycle -> rdata_e=0x1234.
//    mtlo 0xABCD -> lo=0xABCD, rdata_e=0 for op_e=0.

Source files
------------

// File: rtl/mdu_sched.sv
// rtl/mdu_sched.sv - E-stage multiply/divide sequencer owning HI/LO
// Result is computed at start and parked; only the HI/LO commit waits out the busy window.
module mdu_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  op_e,
  input  logic [31:0] rs_e,
  input  logic [31:0] rt_e,
  input  logic        req,
  input  logic        d_is_mdu,
  output logic        busy,
  output logic        stall_d,
  output logic [31:0] rdata_e,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [31:0]    hi_q, hi_d;
  logic [31:0]    lo_q, lo_d;
  logic [31:0]    pend_hi_q, pend_hi_d;
  logic [31:0]    pend_lo_q, pend_lo_d;
  logic           pend_wr_q, pend_wr_d;

  logic           is_mult;
  logic           is_div;
  logic           start;

  logic [63:0]    prod_s;
  logic [63:0]    prod_u;
  logic           div_signed;
  logic           rs_neg;
  logic           rt_neg;
  logic [31:0]    mag_rs;
  logic [31:0]    mag_rt;
  logic [31:0]    div_den;
  logic [31:0]    uquot;
  logic [31:0]    urem;
  logic [31:0]    quot;
  logic [31:0]    rem;
  logic [31:0]    res_hi;
  logic [31:0]    res_lo;

  assign is_mult = (op_e == OP_MULT) || (op_e == OP_MULTU);
  assign is_div  = (op_e == OP_DIV)  || (op_e == OP_DIVU);
  assign start   = (state_q == IDLE) && (is_mult || is_div) && !req;

  // Low 64 bits of a product of sign-extended operands equal the signed product.
  assign prod_u = {32'd0, rs_e} * {32'd0, rt_e};
  assign prod_s = {{32{rs_e[31]}}, rs_e} * {{32{rt_e[31]}}, rt_e};

  // Signed divide on magnitudes: 0x80000000 / -1 falls out as 0x80000000 with no overflow case.
  assign div_signed = (op_e == OP_DIV);
  assign rs_neg     = div_signed && rs_e[31];
  assign rt_neg     = div_signed && rt_e[31];
  assign mag_rs     = rs_neg ? (32'd0 - rs_e) : rs_e;
  assign mag_rt     = rt_neg ? (32'd0 - rt_e) : rt_e;
  assign div_den    = (mag_rt == 32'd0) ? 32'd1 : mag_rt;
  assign uquot      = mag_rs / div_den;
  assign urem       = mag_rs % div_den;
  assign quot       = (rs_neg ^ rt_neg) ? (32'd0 - uquot) : uquot;
  assign rem        = rs_neg ? (32'd0 - urem) : urem;

  always_comb begin
    res_hi = rem;
    res_lo = quot;
    if (op_e == OP_MULT) begin
      res_hi = prod_s[63:32];
      res_lo = prod_s[31:0];
    end else if (op_e == OP_MULTU) begin
      res_hi = prod_u[63:32];
      res_lo = prod_u[31:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          cnt_d     = is_mult ? MULT_LOAD : DIV_LOAD;
          pend_hi_d = res_hi;
          pend_lo_d = res_lo;
          // A zero divisor still occupies the unit but must leave HI/LO alone.
          pend_wr_d = is_mult || (rt_e != 32'd0);
        end else if (!req && (op_e == OP_MTHI)) begin
          hi_d = rs_e;
        end else if (!req && (op_e == OP_MTLO)) begin
          lo_d = rs_e;
        end
      end
      RUN: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = IDLE;
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  assign busy    = (state_q == RUN);
  assign stall_d = d_is_mdu && (busy || start);
  assign hi      = hi_q;
  assign lo      = lo_q;

  always_comb begin
    rdata_e = 32'd0;
    if (op_e == OP_MFHI) begin
      rdata_e = hi_q;
    end else if (op_e == OP_MFLO) begin
      rdata_e = lo_q;
    end
  end

endmodule

// File: tb/tb_mdu_sched.sv
// tb/tb_mdu_sched.sv - scoreboard bench for mdu_sched with a behavioural HI/LO model
// Stimulus pushes expected commits/reads; a negedge monitor pops them as the DUT presents results.
module tb_mdu_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  op_e;
  logic [31:0] rs_e;
  logic [31:0] rt_e;
  logic        req;
  logic        d_is_mdu;
  logic        busy;
  logic        stall_d;
  logic [31:0] rdata_e;
  logic [31:0] hi;
  logic [31:0] lo;

  mdu_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .op_e     (op_e),
    .rs_e     (rs_e),
    .rt_e     (rt_e),
    .req      (req),
    .d_is_mdu (d_is_mdu),
    .busy     (busy),
    .stall_d  (stall_d),
    .rdata_e  (rdata_e),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } commit_t;

  int          total = 0;
  int          bad   = 0;
  commit_t     cq[$];
  logic [31:0] rq[$];
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV division truncates toward zero, % follows the dividend.
  task automatic ref_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] eh, output logic [31:0] el);
    longint          sa, sb, p;
    longint unsigned ua, ub, pu;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    eh = m_hi;
    el = m_lo;
    case (op)
      4'd1: begin p = sa * sb; eh = p[63:32]; el = p[31:0]; end
      4'd2: begin pu = ua * ub; eh = pu[63:32]; el = pu[31:0]; end
      4'd3: if (b != 0) begin p = sa / sb; el = p[31:0]; p = sa % sb; eh = p[31:0]; end
      4'd4: if (b != 0) begin pu = ua / ub; el = pu[31:0]; pu = ua % ub; eh = pu[31:0]; end
      default: ;
    endcase
  endtask

  // Monitor: busy falling means a commit (or an abort if reset was applied at that edge).
  logic busy_prev = 1'b0;
  logic rst_prev  = 1'b1;
  int   bcnt      = 0;

  always @(negedge clk) begin
    commit_t e;
    if (busy_prev && !busy) begin
      if (cq.size() == 0) begin
        chk("unexpected_commit", 32'd1, 32'd0);
      end else begin
        e = cq.pop_front();
        if (rst_prev) begin
          chk("abort_hi", hi, 32'd0);
          chk("abort_lo", lo, 32'd0);
        end else begin
          chk("commit_hi", hi, e.hi);
          chk("commit_lo", lo, e.lo);
          chk("busy_cycles", bcnt, e.cycles);
        end
      end
      bcnt = 0;
    end
    if (busy) bcnt++;
    if (!reset && (op_e == 4'd5 || op_e == 4'd6)) begin
      if (rq.size() == 0) chk("unexpected_read", 32'd1, 32'd0);
      else chk("rdata", rdata_e, rq.pop_front());
    end
    assert (!(busy && op_e >= 4'd1 && op_e <= 4'd4))
      else $error("mult/div issued while busy at %0t", $time);
    busy_prev = busy;
    rst_prev  = reset;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic dmdu, input logic rq_run);
    logic [31:0] eh, el;
    int n;
    cyc();
    op_e = op; rs_e = a; rt_e = b; req = 1'b0; d_is_mdu = dmdu;
    ref_md(op, a, b, eh, el);
    cq.push_back('{hi: eh, lo: el, cycles: (op <= 4'd2) ? 5 : 10});
    m_hi = eh;
    m_lo = el;
    #1;
    chk("start_stall", stall_d, dmdu);
    chk("start_not_busy", busy, 32'd0);
    cyc();
    op_e = 4'd0; rs_e = $urandom; rt_e = $urandom; req = rq_run;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      chk("run_stall", stall_d, dmdu);
      n++;
      cyc();
    end
    if (n >= 40) chk("busy_timeout", busy, 32'd0);
    req = 1'b0;
    #1;
    chk("stall_drop", stall_d, 32'd0);
    d_is_mdu = 1'b0;
  endtask

  task automatic do_mt(input logic sel_lo, input logic [31:0] v, input logic rq_in);
    cyc();
    op_e = sel_lo ? 4'd8 : 4'd7; rs_e = v; req = rq_in; d_is_mdu = 1'b0;
    if (!rq_in) begin
      if (sel_lo) m_lo = v; else m_hi = v;
    end
    cyc();
    op_e = 4'd0; req = 1'b0;
    chk("mt_hi", hi, m_hi);
    chk("mt_lo", lo, m_lo);
  endtask

  task automatic do_mf(input logic sel_lo);
    cyc();
    op_e = sel_lo ? 4'd6 : 4'd5; req = 1'b0;
    rq.push_back(sel_lo ? m_lo : m_hi);
  endtask

  task automatic do_req_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    cyc();
    op_e = op; rs_e = a; rt_e = b; req = 1'b1; d_is_mdu = 1'b1;
    #1;
    chk("req_no_stall", stall_d, 32'd0);
    cyc();
    op_e = 4'd0; req = 1'b0; d_is_mdu = 1'b0;
    chk("req_no_busy", busy, 32'd0);
    chk("req_hi", hi, m_hi);
    chk("req_lo", lo, m_lo);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1);
  end

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b;
    reset = 1'b1; op_e = 4'd0; rs_e = 32'd0; rt_e = 32'd0; req = 1'b0; d_is_mdu = 1'b1;
    cyc();
    cyc();
    chk("rst_busy", busy, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_stall", stall_d, 32'd0);
    chk("rst_rdata", rdata_e, 32'd0);
    reset = 1'b0; d_is_mdu = 1'b0;

    do_md(4'd1, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b0);
    chk("mult_hi_dir", hi, 32'hFFFFFFFF);
    chk("mult_lo_dir", lo, 32'hFFFFFFFA);
    do_md(4'd2, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b0);
    chk("multu_hi_dir", hi, 32'h00000002);
    do_md(4'd3, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
    chk("div_lo_dir", lo, 32'hFFFFFFFD);
    chk("div_hi_dir", hi, 32'hFFFFFFFF);
    do_md(4'd4, 32'd7, 32'd0, 1'b0, 1'b0);
    do_md(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
    chk("div_ovf_lo", lo, 32'h80000000);
    chk("div_ovf_hi", hi, 32'h00000000);

    do_md(4'd1, 32'd1000, 32'hFFFFFFFF, 1'b1, 1'b0);
    do_mf(1'b1);
    do_req_md(4'd3, 32'd100, 32'd7);
    cyc();
    op_e = 4'd7; rs_e = 32'hDEAD; req = 1'b1; d_is_mdu = 1'b0;
    cyc();
    op_e = 4'd0; req = 1'b0;
    chk("req_mthi_hi", hi, m_hi);
    do_md(4'd2, 32'h12345678, 32'h9ABCDEF0, 1'b1, 1'b1);

    // Abort: reset asserted during the third busy cycle.
    cyc();
    op_e = 4'd1; rs_e = 32'd77; rt_e = 32'd99; d_is_mdu = 1'b0;
    cq.push_back('{hi: 32'd0, lo: 32'd0, cycles: 5});
    cyc(); op_e = 4'd0;
    cyc();
    cyc(); reset = 1'b1; d_is_mdu = 1'b1;
    cyc(); reset = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    chk("abort_busy", busy, 32'd0);
    chk("abort_stall", stall_d, 32'd0);
    d_is_mdu = 1'b0;

    do_mt(1'b0, 32'h1234, 1'b0);
    do_mf(1'b0);
    do_mt(1'b1, 32'hABCD, 1'b0);
    cyc();
    op_e = 4'd0;
    #1;
    chk("rdata_none", rdata_e, 32'd0);

    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 5))
        0, 1: begin
          op = 4'($urandom_range(1, 4));
          a  = ($urandom_range(0, 4) == 0) ? 32'h80000000 : $urandom;
          case ($urandom_range(0, 4))
            0: b = 32'd0;
            1: b = 32'hFFFFFFFF;
            default: b = $urandom;
          endcase
          do_md(op, a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        2: do_mt(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
        3, 4: do_mf(1'($urandom_range(0, 1)));
        default: do_req_md(4'($urandom_range(1, 4)), $urandom, $urandom);
      endcase
    end

    cyc();
    op_e = 4'd0;
    repeat (3) cyc();
    chk("commit_q_drained", cq.size(), 32'd0);
    chk("read_q_drained", rq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
